// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all domain resets asynchronously, releases them one by one
// after the PLL lock is stable. Optional watchdog is built when RST_SEQ_WDT_EN is defined.
module rst_seq_ctrl #(
   parameter int unsigned NUM_DOMAINS     = 3,
   parameter int unsigned LOCK_FILTER     = 2,
   parameter int unsigned HOLD_CYCLES     = 10,
   parameter int unsigned STAGE_GAP       = 4,
   parameter int unsigned SOFT_RST_CYCLES = 8,
   parameter int unsigned WDT_CYCLES      = 65536
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   pll_locked_i,
   input  logic                   soft_rst_req_i,
   input  logic                   wdt_kick_i,
   output logic [NUM_DOMAINS-1:0] rst_no,
   output logic                   busy_o,
   output logic [1:0]             rst_cause_o
);

   // state     | meaning
   // WAIT_LOCK | all resets asserted, filtering synchronized PLL lock
   // HOLD      | lock stable, counting HOLD_CYCLES before domain 0 releases
   // RELEASE   | releasing domains 1..NUM_DOMAINS-1, STAGE_GAP cycles apart
   // RUN       | all domains out of reset
   // SOFT      | soft/watchdog reset, all resets asserted for SOFT_RST_CYCLES

   localparam int unsigned MAX_A   = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
   localparam int unsigned MAX_B   = (STAGE_GAP > SOFT_RST_CYCLES) ? STAGE_GAP : SOFT_RST_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned IW      = $clog2(NUM_DOMAINS + 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      SOFT      = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             sync_q;
   logic                   lock_s;
   logic [CW-1:0]          lock_cnt_q, lock_cnt_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic [1:0]             cause_q, cause_d;
   logic                   wdt_fire;

   assign lock_s = sync_q[1];

`ifdef RST_SEQ_WDT_EN
   localparam int unsigned WW = $clog2(WDT_CYCLES + 1);

   logic [WW-1:0] wdt_q, wdt_d;

   // Counter only advances in RUN; a kick on the terminal cycle wins over the timeout.
   always_comb begin
      wdt_d    = '0;
      wdt_fire = 1'b0;
      if (state_q == RUN) begin
         if (wdt_kick_i) begin
            wdt_d = '0;
         end else if (wdt_q == WW'(WDT_CYCLES - 1)) begin
            wdt_fire = 1'b1;
         end else begin
            wdt_d = wdt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
   logic unused_wdt_kick;
   assign unused_wdt_kick = wdt_kick_i;
   assign wdt_fire        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rst_d      = rst_q;
      cause_d    = cause_q;

      case (state_q)
         WAIT_LOCK: begin
            rst_d = '0;
            if (lock_s) begin
               if (lock_cnt_q == CW'(LOCK_FILTER - 1)) begin
                  lock_cnt_d = '0;
                  cnt_d      = '0;
                  state_d    = HOLD;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end else begin
               lock_cnt_d = '0;
            end
         end
         HOLD: begin
            if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
               cnt_d    = '0;
               rst_d[0] = 1'b1;
               idx_d    = IW'(1);
               state_d  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (cnt_q == CW'(STAGE_GAP - 1)) begin
               cnt_d = '0;
               for (int k = 0; k < NUM_DOMAINS; k++) begin
                  if (idx_q == IW'(k)) rst_d[k] = 1'b1;
               end
               if (idx_q == IW'(NUM_DOMAINS - 1)) begin
                  idx_d   = '0;
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            rst_d = '1;
            if (wdt_fire) begin
               rst_d   = '0;
               cnt_d   = '0;
               cause_d = 2'b11;
               state_d = SOFT;
            end else if (soft_rst_req_i) begin
               rst_d   = '0;
               cnt_d   = '0;
               cause_d = 2'b10;
               state_d = SOFT;
            end
         end
         SOFT: begin
            rst_d = '0;
            if (cnt_q == CW'(SOFT_RST_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            rst_d      = '0;
            lock_cnt_d = '0;
            cnt_d      = '0;
            idx_d      = '0;
            state_d    = WAIT_LOCK;
         end
      endcase

      // Lock loss overrides every other event, including ones decided above.
      if ((state_q != WAIT_LOCK) && !lock_s) begin
         rst_d      = '0;
         lock_cnt_d = '0;
         cnt_d      = '0;
         idx_d      = '0;
         cause_d    = 2'b01;
         state_d    = WAIT_LOCK;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= WAIT_LOCK;
         sync_q     <= '0;
         lock_cnt_q <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_q      <= '0;
         cause_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[0], pll_locked_i};
         lock_cnt_q <= lock_cnt_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rst_q      <= rst_d;
         cause_q    <= cause_d;
      end
   end

   assign rst_no      = rst_q;
   assign busy_o      = ~&rst_q;
   assign rst_cause_o = cause_q;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Synthesizable, parametrised reset sequencer for the demo SoC; replaces the fixed single-reset, time-delay release used in simulation.
- Asserts all domain resets asynchronously and releases them synchronously, one domain after another, once the PLL lock is stable.
- Also supports software-requested reset and reports the cause of the last reset.
- Sits between the clock/PLL block and the core, RAM and UART domains of demo_top.

Parameters:
- NUM_DOMAINS, 3, number of reset outputs; released in index order 0..NUM_DOMAINS-1; range 1..8.
- LOCK_FILTER, 2, consecutive cycles pll_locked_i must be high before sequencing starts; >=1.
- HOLD_CYCLES, 10, cycles in HOLD before rst_no[0] releases; >=1.
- STAGE_GAP, 4, cycles between release of rst_no[k-1] and rst_no[k]; >=1.
- SOFT_RST_CYCLES, 8, cycles all resets stay asserted after a soft request; >=1.
- WDT_CYCLES, 65536, watchdog timeout in cycles; used only with RST_SEQ_WDT_EN.

Ports:
- clk_i  in  1  system clock (PLL output).
- rst_ni  in  1  asynchronous active-low reset (power-on / board reset).
- pll_locked_i  in  1  PLL lock indicator; asynchronous, double-flop synchronized internally.
- soft_rst_req_i  in  1  single-cycle software reset request (clk_i domain).
- wdt_kick_i  in  1  watchdog restart pulse; ignored without RST_SEQ_WDT_EN.
- rst_no  out  NUM_DOMAINS  active-low domain resets, registered.
- busy_o  out  1  high while any rst_no bit is low.
- rst_cause_o  out  2  cause of last reset: 00 por, 01 lock lost, 10 soft, 11 watchdog.

Behaviour:
- Reset values (rst_ni low):
  - rst_no = all 0, busy_o = 1, rst_cause_o = 00, state = WAIT_LOCK, all counters 0.
  - Assertion is asynchronous, i.e. immediate.
  - All deassertion happens on clk_i rising edges.
- Lock synchronizer: 2 flops, also reset by rst_ni. Define lock_s as its output.
- States:
  - WAIT_LOCK: lock_cnt increments while lock_s is 1 and clears when lock_s is 0. When lock_cnt reaches LOCK_FILTER: clear lock_cnt, go to HOLD.
  - HOLD: cnt increments each cycle. After HOLD_CYCLES cycles: rst_no[0] goes to 1 on that edge, idx = 1, go to RELEASE (or to RUN if NUM_DOMAINS = 1).
  - RELEASE: every STAGE_GAP cycles, rst_no[idx] goes to 1 and idx increments. The edge that releases idx = NUM_DOMAINS-1 also moves to RUN and drives busy_o to 0.
  - RUN: all rst_no = 1, busy_o = 0.
  - SOFT: all rst_no = 0. After SOFT_RST_CYCLES cycles, go to HOLD. Lock filtering is skipped because lock is already stable.
- Events:
  - Lock loss (lock_s = 0) in any state other than WAIT_LOCK:
    - On the next edge: rst_no = 0, busy_o = 1, rst_cause_o = 01, counters cleared, go to WAIT_LOCK.
  - soft_rst_req_i:
    - Acted on only in RUN. Next edge: rst_no = 0, busy_o = 1, rst_cause_o = 10, go to SOFT.
    - Ignored (not latched) in every other state.
- Priority when events coincide on the same cycle: lock loss > watchdog > soft request.
- Counters: width $clog2(max parameter + 1). No wrap is possible because every counter clears on its terminal count.
- rst_cause_o holds its value until the next reset event. It is not cleared on entering RUN.
- Releasing rst_ni mid-sequence restarts the whole sequence from WAIT_LOCK.

Optional Feature:
- Macro: RST_SEQ_WDT_EN.
- Defined:
  - A watchdog counter runs only in RUN and clears on wdt_kick_i.
  - When it reaches WDT_CYCLES-1 without a kick: next edge sets rst_no = 0, busy_o = 1, rst_cause_o = 11, and goes to SOFT (same hold and release timing as a soft reset).
  - The counter clears on leaving RUN.
- Not defined: no watchdog logic is present, wdt_kick_i is unused, and rst_cause_o never takes the value 11.

Test Plan:
- POR sequence:
  - Stimulus: defaults; pll_locked_i = 1 throughout; rst_ni released. Edge 1 is the first clk_i edge with rst_ni high.
  - Required: rst_no[0] rises at edge 14 (2 sync + 2 filter + 10 hold), rst_no[1] at edge 18, rst_no[2] at edge 22. busy_o falls at edge 22. rst_cause_o = 00.
- Lock glitch filter:
  - Stimulus: pll_locked_i toggles 1 for 1 cycle, then 0, during WAIT_LOCK.
  - Required: no state change, rst_no stays 000. Sequencing starts only after 2 consecutive high cycles.
- Lock loss in RUN:
  - Stimulus: drop pll_locked_i.
  - Required: rst_no = 000 three edges later (2 sync edges + 1); rst_cause_o = 01. On relock, the full POR timing repeats.
- Soft reset:
  - Stimulus: 1-cycle soft_rst_req_i pulse in RUN.
  - Required: rst_no = 000 next edge, 8 cycles held, 10 hold, then staggered releases 4 cycles apart. rst_cause_o = 10. A second pulse during SOFT has no effect.
- Simultaneous events:
  - Stimulus: soft_rst_req_i pulse on the same cycle lock_s falls.
  - Required: rst_cause_o = 01, state = WAIT_LOCK.
- Watchdog (with RST_SEQ_WDT_EN, WDT_CYCLES = 16):
  - Stimulus: no kicks in RUN.
  - Required: reset asserts 16 cycles after RUN entry, rst_cause_o = 11. With a kick every 10 cycles, no reset occurs.
